// File: rtl/keypad_event_fifo.sv
// Matrix keypad scanner with frame debounce and a show-ahead event FIFO.
// Define KEY_RELEASE_EVENT_EN to also queue key-release events (MSB = 1).
module keypad_event_fifo #(
  parameter int ROWS     = 4,
  parameter int COLS     = 4,
  parameter int SCAN_DIV = 50000,
  parameter int DEBOUNCE = 4,
  parameter int DEPTH    = 8,
  localparam int NKEYS   = ROWS * COLS,
  localparam int CODE_W  = (NKEYS > 1) ? $clog2(NKEYS) : 1,
`ifdef KEY_RELEASE_EVENT_EN
  localparam int DW      = CODE_W + 1,
`else
  localparam int DW      = CODE_W,
`endif
  localparam int CW      = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [ROWS-1:0] row,
  output logic [COLS-1:0] col,
  output logic [DW-1:0] key_data,
  output logic          key_valid,
  input  logic          key_ready,
  output logic [CW-1:0] fifo_count,
  output logic          overflow,
  input  logic          clr_ovf
);

  localparam int AW     = $clog2(DEPTH);
  localparam int DIV_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int COL_W  = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int STAB_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;

  localparam logic [1:0] ST_SCAN  = 2'd0;
  localparam logic [1:0] ST_CHECK = 2'd1;
  localparam logic [1:0] ST_EMIT  = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [COL_W-1:0]  col_idx_q, col_idx_d;
  logic [DIV_W-1:0]  dwell_q, dwell_d;
  logic [NKEYS-1:0]  frame_q, frame_d;
  logic [NKEYS-1:0]  prev_q, prev_d;
  logic [STAB_W-1:0] stab_q, stab_d;
  logic [NKEYS-1:0]  committed_q, committed_d;
  logic [NKEYS-1:0]  edges_q, edges_d;
`ifdef KEY_RELEASE_EVENT_EN
  logic [NKEYS-1:0]  rels_q, rels_d;
`endif

  logic [NKEYS-1:0]  col_sel, row_spread;
  logic [NKEYS-1:0]  pend_vec, pend_low;
  logic [CODE_W-1:0] pend_code;
  logic              push_req;
  logic [DW-1:0]     push_data;

  // Map each key code r*COLS+c onto the active column and its row input.
  for (genvar gi = 0; gi < ROWS; gi++) begin : g_row
    for (genvar gj = 0; gj < COLS; gj++) begin : g_col
      assign col_sel[gi*COLS+gj]    = (col_idx_q == COL_W'(gj));
      assign row_spread[gi*COLS+gj] = ~row[gi];
    end
  end

  for (genvar gj = 0; gj < COLS; gj++) begin : g_drive
    assign col[gj] = (col_idx_q != COL_W'(gj));
  end

`ifdef KEY_RELEASE_EVENT_EN
  assign pend_vec = (|edges_q) ? edges_q : rels_q;
`else
  assign pend_vec = edges_q;
`endif
  // Isolate the lowest pending bit, then binary-encode the one-hot result.
  assign pend_low = pend_vec & (~pend_vec + NKEYS'(1));

  for (genvar gb = 0; gb < CODE_W; gb++) begin : g_enc
    logic [NKEYS-1:0] mask;
    for (genvar gk = 0; gk < NKEYS; gk++) begin : g_bit
      assign mask[gk] = (((gk >> gb) & 1) == 1);
    end
    assign pend_code[gb] = |(pend_low & mask);
  end

  always_comb begin
    state_d     = state_q;
    col_idx_d   = col_idx_q;
    dwell_d     = dwell_q;
    frame_d     = frame_q;
    prev_d      = prev_q;
    stab_d      = stab_q;
    committed_d = committed_q;
    edges_d     = edges_q;
`ifdef KEY_RELEASE_EVENT_EN
    rels_d      = rels_q;
`endif
    push_req    = 1'b0;
    push_data   = '0;
    case (state_q)
      ST_SCAN: begin
        if (dwell_q == DIV_W'(SCAN_DIV - 1)) begin
          dwell_d = '0;
          frame_d = (frame_q & ~col_sel) | (row_spread & col_sel);
          if (col_idx_q == COL_W'(COLS - 1)) begin
            col_idx_d = '0;
            state_d   = ST_CHECK;
          end else begin
            col_idx_d = col_idx_q + COL_W'(1);
          end
        end else begin
          dwell_d = dwell_q + DIV_W'(1);
        end
      end
      ST_CHECK: begin
        prev_d = frame_q;
        if (frame_q == prev_q) begin
          if (stab_q != STAB_W'(DEBOUNCE - 1)) stab_d = stab_q + STAB_W'(1);
        end else begin
          stab_d = '0;
        end
        if (stab_d == STAB_W'(DEBOUNCE - 1) && frame_q != committed_q) begin
          state_d = ST_EMIT;
          edges_d = frame_q & ~committed_q;
`ifdef KEY_RELEASE_EVENT_EN
          rels_d  = committed_q & ~frame_q;
`endif
        end else begin
          state_d = ST_SCAN;
        end
      end
      ST_EMIT: begin
        if (|edges_q) begin
          push_req  = 1'b1;
          push_data = DW'(pend_code);
          edges_d   = edges_q & (edges_q - NKEYS'(1));
        end
`ifdef KEY_RELEASE_EVENT_EN
        else if (|rels_q) begin
          push_req  = 1'b1;
          push_data = {1'b1, pend_code};
          rels_d    = rels_q & (rels_q - NKEYS'(1));
        end
`endif
        else begin
          committed_d = frame_q;
          state_d     = ST_SCAN;
          col_idx_d   = '0;
          dwell_d     = '0;
        end
      end
      default: state_d = ST_SCAN;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_SCAN;
      col_idx_q   <= '0;
      dwell_q     <= '0;
      frame_q     <= '0;
      prev_q      <= '0;
      stab_q      <= '0;
      committed_q <= '0;
      edges_q     <= '0;
`ifdef KEY_RELEASE_EVENT_EN
      rels_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      col_idx_q   <= col_idx_d;
      dwell_q     <= dwell_d;
      frame_q     <= frame_d;
      prev_q      <= prev_d;
      stab_q      <= stab_d;
      committed_q <= committed_d;
      edges_q     <= edges_d;
`ifdef KEY_RELEASE_EVENT_EN
      rels_q      <= rels_d;
`endif
    end
  end

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [DW-1:0] head_q, head_d;
  logic          valid_q, valid_d;
  logic          ovf_q, ovf_d;
  logic          pop, full, push_ok, ovf_set;

  // A pop frees a slot in the same cycle, so a full FIFO can still accept a push.
  assign pop      = valid_q & key_ready;
  assign full     = (count_q == CW'(DEPTH));
  assign push_ok  = push_req & (~full | pop);
  assign ovf_set  = push_req & full & ~pop;
  assign wr_ptr_d = wr_ptr_q + AW'(push_ok);
  assign rd_ptr_d = rd_ptr_q + AW'(pop);
  assign count_d  = count_q + CW'(push_ok) - CW'(pop);
  assign valid_d  = (count_d != '0);
  assign head_d   = (push_ok && rd_ptr_d == wr_ptr_q) ? push_data : mem_q[rd_ptr_d];
  assign ovf_d    = ovf_set ? 1'b1 : (clr_ovf ? 1'b0 : ovf_q);

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
      valid_q  <= valid_d;
      ovf_q    <= ovf_d;
    end
  end

  assign key_data   = head_q;
  assign key_valid  = valid_q;
  assign fifo_count = count_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_keypad_event_fifo.sv
// Directed bench for keypad_event_fifo: 4x4 keypad, SCAN_DIV=4, DEBOUNCE=2, DEPTH=4.
module tb_keypad_event_fifo;
  localparam int ROWS = 4, COLS = 4, SCAN_DIV = 4, DEBOUNCE = 2, DEPTH = 4;
`ifdef KEY_RELEASE_EVENT_EN
  localparam int DW = 5;
`else
  localparam int DW = 4;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic [3:0]    row;
  logic [3:0]    col;
  logic [DW-1:0] key_data;
  logic          key_valid;
  logic          key_ready;
  logic [2:0]    fifo_count;
  logic          overflow;
  logic          clr_ovf;
  logic [15:0]   pressed;

  int errors = 0;
  int checks = 0;

  keypad_event_fifo #(
    .ROWS(ROWS), .COLS(COLS), .SCAN_DIV(SCAN_DIV), .DEBOUNCE(DEBOUNCE), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .row(row), .col(col), .key_data(key_data),
    .key_valid(key_valid), .key_ready(key_ready), .fifo_count(fifo_count),
    .overflow(overflow), .clr_ovf(clr_ovf)
  );

  always #5 clk = ~clk;

  // Closed key pulls its row low while its column is driven low.
  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !col[c]) row[r] = 1'b0;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      $display("check %-18s observed=%0h expected=%0h", tag, obs, exp);
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic hold(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Returns at the negedge of the CHECK cycle (column 3 just finished).
  task automatic wait_check_edge(output bit ok);
    logic [3:0] prev;
    ok = 1'b0;
    prev = col;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (prev == 4'b0111 && col == 4'b1110) begin
        ok = 1'b1;
        break;
      end
      prev = col;
    end
  endtask

  task automatic wait_count(input int target, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (fifo_count == 3'(target)) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic pop_one();
    key_ready = 1'b1;
    tick();
    key_ready = 1'b0;
  endtask

  initial begin
    bit ok, ok2, ok3, seen;
    int n, c1, c2;
    logic [DW-1:0] exp_q [$];
    reset = 1'b1; key_ready = 1'b0; clr_ovf = 1'b0; pressed = '0;
    hold(3);
    check("rst_col", col, 4'b1110);
    check("rst_key_data", key_data, 0);
    check("rst_key_valid", key_valid, 0);
    check("rst_fifo_count", fifo_count, 0);
    check("rst_overflow", overflow, 0);
    reset = 1'b0;

`ifndef KEY_RELEASE_EVENT_EN
    // 1: held key r1,c2 gives exactly one event 6
    key_ready = 1'b1;
    pressed = 16'(1) << 6;
    seen = 1'b0;
    for (int i = 0; i < 150; i++) begin
      tick();
      if (key_valid) begin seen = 1'b1; break; end
    end
    check("t1_seen", seen, 1);
    check("t1_data", key_data, 6);
    tick();
    check("t1_valid_1clk", key_valid, 0);
    n = 0;
    repeat (60) begin tick(); if (key_valid) n++; end
    check("t1_no_repeat", n, 0);
    pressed = '0;
    hold(80);
    check("t1_count", fifo_count, 0);

    // 2: key 0 present for a single frame is filtered
    wait_check_edge(ok);
    check("t2_align", ok, 1);
    pressed = 16'(1) << 0;
    n = 0;
    repeat (17) begin tick(); if (key_valid || fifo_count != 0) n++; end
    pressed = '0;
    repeat (80) begin tick(); if (key_valid || fifo_count != 0) n++; end
    check("t2_no_event", n, 0);

    // 3: five keystrokes into a 4-deep FIFO with no consumer
    key_ready = 1'b0;
    foreach (exp_q[i]) exp_q.delete(i);
    begin
      int keys [5] = '{3, 7, 9, 12, 15};
      foreach (keys[i]) begin
        pressed = 16'(1) << keys[i];
        hold(80);
        pressed = '0;
        hold(80);
      end
    end
    check("t3_count_full", fifo_count, 4);
    check("t3_overflow", overflow, 1);
    check("t3_head", key_data, 3);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    check("t3_clr_ovf", overflow, 0);

    // full FIFO: push of key 10 coincides with a pop of the head
    wait_check_edge(ok);
    pressed = 16'(1) << 10;
    wait_check_edge(ok2);
    wait_check_edge(ok3);
    check("t3_align", ok & ok2 & ok3, 1);
    tick();
    pop_one();
    check("t3_pushpop_count", fifo_count, 4);
    check("t3_pushpop_ovf", overflow, 0);
    exp_q = '{4'd7, 4'd9, 4'd12, 4'd10};
    foreach (exp_q[i]) begin
      check("t3_pop_data", key_data, exp_q[i]);
      pop_one();
    end
    check("t3_drained", fifo_count, 0);
    pressed = '0;
    hold(80);

    // 4: two simultaneous presses, ascending order, back-to-back pushes
    pressed = (16'(1) << 1) | (16'(1) << 11);
    c1 = -1; c2 = -1;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (fifo_count == 3'd1 && c1 < 0) c1 = i;
      if (fifo_count == 3'd2) begin c2 = i; break; end
    end
    check("t4_consecutive", c2 - c1, 1);
    check("t4_first", key_data, 1);
    pop_one();
    check("t4_second", key_data, 11);
    pop_one();
    check("t4_empty", key_valid, 0);
    pressed = '0;
    hold(80);

    // 5: reset lands mid-EMIT with two events queued
    pressed = (16'(1) << 1) | (16'(1) << 11) | (16'(1) << 14);
    wait_count(2, ok);
    check("t5_reach2", ok, 1);
    reset = 1'b1;
    tick();
    check("t5_valid", key_valid, 0);
    check("t5_count", fifo_count, 0);
    check("t5_col", col, 4'b1110);
    hold(2);
    reset = 1'b0;
    wait_count(3, ok);
    check("t5_rereport", ok, 1);
    exp_q = '{4'd1, 4'd11, 4'd14};
    foreach (exp_q[i]) begin
      check("t5_pop_data", key_data, exp_q[i]);
      pop_one();
    end
    check("t5_drained", fifo_count, 0);
    pressed = '0;
    hold(80);
`else
    // 6: press then release key 5 yields a press and a release event
    key_ready = 1'b0;
    pressed = 16'(1) << 5;
    hold(80);
    pressed = '0;
    hold(80);
    check("t6_count", fifo_count, 2);
    check("t6_press", key_data, 5'h05);
    pop_one();
    check("t6_release", key_data, 5'h15);
    pop_one();
    check("t6_empty", fifo_count, 0);
    check("t6_overflow", overflow, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
